// File: rtl/kscan_pkg.sv
// rtl/kscan_pkg.sv - shared types and sizing helpers for the keypad scanner
package kscan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kscan_state_e;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int key_width(input int rows, input int cols);
    return idx_width(rows * cols);
  endfunction

endpackage

// File: rtl/kscan_debounce.sv
// rtl/kscan_debounce.sv - saturating stable-level counter shared by press and release debounce
module kscan_debounce #(
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic en,
  input  logic level,
  input  logic target,
  output logic done,
  output logic fail
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match;

  assign match = (level == target);
  assign done  = en && match && (cnt_q == CNT_LAST);
  assign fail  = en && !match;

  // Clear on start, count stable cycles while enabled, hold at the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (en && match && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - row-scanning matrix keypad controller with press/release debounce
module keypad_scan import kscan_pkg::*; #(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 8,
  localparam int KW          = key_width(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] cols,
  output logic [ROWS-1:0] rows,
  output logic [KW-1:0]   key,
  output logic            key_valid,
  output logic            key_held
);

  localparam int RW      = idx_width(ROWS);
  localparam int CW      = idx_width(COLS);
  localparam int DWELL_W = $clog2(SCAN_DIV) + 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);

  kscan_state_e      state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [ROWS-1:0]   rows_q, rows_d;
  logic [KW-1:0]     key_q, key_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

  logic              any_low;
  logic [CW-1:0]     col_sel;
  logic [RW-1:0]     next_row;
  logic [KW-1:0]     code;
  logic              col_level;
  logic              db_start, db_en, db_target, db_done, db_fail;

  assign next_row  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign code      = KW'(int'(row_q) * COLS + int'(col_q));
  assign col_level = cols[col_q];

  // Lowest-index active-low column wins
  always_comb begin
    any_low = 1'b0;
    col_sel = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!cols[c]) begin
        any_low = 1'b1;
        col_sel = CW'(c);
      end
    end
  end

  kscan_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .start  (db_start),
    .en     (db_en),
    .level  (col_level),
    .target (db_target),
    .done   (db_done),
    .fail   (db_fail)
  );

  // Scan / debounce / hold sequencing; the row stays frozen outside SCAN
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    dwell_d     = dwell_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    db_start    = 1'b0;
    db_en       = 1'b0;
    db_target   = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (any_low) begin
            col_d    = col_sel;
            db_start = 1'b1;
            state_d  = PRESS_DB;
          end else begin
            row_d = next_row;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      PRESS_DB: begin
        db_en     = 1'b1;
        db_target = 1'b0;
        if (db_fail) begin
          row_d   = next_row;
          state_d = SCAN;
        end else if (db_done) begin
          key_d       = code;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end
      end
      HELD: begin
        if (col_level) begin
          db_start = 1'b1;
          state_d  = REL_DB;
        end
      end
      REL_DB: begin
        db_en     = 1'b1;
        db_target = 1'b1;
        if (db_fail) begin
          state_d = HELD;
        end else if (db_done) begin
          key_held_d = 1'b0;
          row_d      = next_row;
          dwell_d    = '0;
          state_d    = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
    rows_d = ~(ROWS'(1) << row_d);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      row_q       <= '0;
      col_q       <= '0;
      dwell_q     <= '0;
      rows_q      <= ~ROWS'(1);
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      rows_q      <= rows_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign rows      = rows_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - scoreboard bench for keypad_scan with a keypad matrix model
module tb_keypad_scan;
  import kscan_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DB   = 8;
  localparam int KW   = key_width(ROWS, COLS);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [COLS-1:0] cols;
  logic [ROWS-1:0] rows;
  logic [KW-1:0]   key;
  logic            key_valid;
  logic            key_held;

  logic pressed [ROWS][COLS];
  int   exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  keypad_scan #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_CNT(DB)
  ) dut (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed switch pulls its column low while its row is driven low
  always_comb begin
    cols = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!rows[r] && pressed[r][c]) cols[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ROWS-1:0] row_pat(input int r);
    logic [ROWS-1:0] p;
    p = '1;
    p[r % ROWS] = 1'b0;
    return p;
  endfunction

  // Scoreboard monitor: every key_valid pulse must match the oldest expected code
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_key_valid", 1, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("key_code", key, e);
        check("key_held_with_valid", key_held, 1);
      end
    end
  end

  task automatic clear_keys();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pressed[r][c] = 1'b0;
  endtask

  task automatic begin_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_keys();
  endtask

  task automatic end_reset();
    @(negedge clk);
    check("reset_rows", rows, 4'b1110);
    check("reset_key", key, 0);
    check("reset_key_valid", key_valid, 0);
    check("reset_key_held", key_held, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int exp_n);
    bit seen;
    seen = 1'b0;
    for (int n = 1; n <= 200 && !seen; n++) begin
      @(negedge clk);
      if (key_valid) begin
        seen = 1'b1;
        check("press_latency", n, exp_n);
      end
    end
    if (!seen) check("key_valid_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Press from reset, hold with distractor keys, optional release glitch, clean release
  task automatic press_hold(input int r, input int c, input int glitch, input int hold);
    begin_reset();
    pressed[r][c] = 1'b1;
    exp_q.push_back(r * COLS + c);
    end_reset();
    wait_valid(4 * r + 4 + DB);
    pressed[r][(c + 1) % COLS] = 1'b1;
    pressed[(r + 1) % ROWS][$urandom_range(0, COLS - 1)] = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rows_frozen", rows, row_pat(r));
      check("hold_key_held", key_held, 1);
    end
    if (glitch > 0) begin
      pressed[r][c] = 1'b0;
      for (int i = 0; i < glitch; i++) begin
        @(negedge clk);
        check("glitch_key_held", key_held, 1);
      end
      pressed[r][c] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("reheld_key_held", key_held, 1);
      end
    end
    clear_keys();
    for (int k = 1; k <= DB + 1; k++) begin
      @(negedge clk);
      if (k <= DB) begin
        check("release_key_held", key_held, 1);
      end else begin
        check("release_key_held_fall", key_held, 0);
        check("release_rows_next", rows, row_pat(r + 1));
      end
    end
    idle(20);
  endtask

  // Short press of b low cycles starting at the row's sample point
  task automatic press_bounce(input int r, input int c, input int b);
    begin_reset();
    pressed[r][c] = 1'b1;
    end_reset();
    idle(4 * r + 3 + b);
    clear_keys();
    @(negedge clk);
    check("bounce_resume_row", rows, row_pat(r + 1));
    check("bounce_key_held", key_held, 0);
    idle(30);
  endtask

  task automatic press_multi(input int r, input int c1, input int c2);
    begin_reset();
    pressed[r][c1] = 1'b1;
    pressed[r][c2] = 1'b1;
    exp_q.push_back(r * COLS + ((c1 < c2) ? c1 : c2));
    end_reset();
    wait_valid(4 * r + 4 + DB);
    idle(5);
    clear_keys();
    idle(DB + 25);
  endtask

  initial begin
    int r, c, c2;
    clear_keys();

    // Idle scan after reset
    begin_reset();
    end_reset();
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      check("idle_scan_rows", rows, row_pat(n / 4));
    end

    press_hold(2, 1, 0, 6);
    press_bounce(1, 3, 5);
    press_hold(0, 0, 3, 4);
    press_multi(0, 0, 2);

    // Reset on the 4th press-debounce cycle of row 1
    begin_reset();
    pressed[1][2] = 1'b1;
    end_reset();
    idle(4 * 1 + 7);
    begin_reset();
    end_reset();
    idle(40);

    // Reset while a key is held
    begin_reset();
    pressed[3][3] = 1'b1;
    exp_q.push_back(15);
    end_reset();
    wait_valid(4 * 3 + 4 + DB);
    idle(3);
    begin_reset();
    end_reset();
    idle(40);

    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      press_hold(r, c, (i % 2 == 0) ? $urandom_range(1, DB) : 0, $urandom_range(2, 10));
    end
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      press_bounce(r, c, $urandom_range(1, DB));
    end
    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      c2 = (c + $urandom_range(1, COLS - 1)) % COLS;
      press_multi(r, c, c2);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Matrix keypad scanner sitting directly downstream of the column-input 2-flop synchronizer.
- Drives one keypad row low at a time and samples the synchronized active-low column lines.
- Debounces press and release, then reports one encoded key code per press with a single-cycle valid pulse.
- Output feeds the display/key-history logic.

Parameters:
- ROWS, 4, number of row drive lines.
- COLS, 4, number of column sense lines.
- SCAN_DIV, 4, clock cycles each row is driven before its columns are sampled. Must be ≥3 to cover the 2-cycle synchronizer latency plus settling.
- DEBOUNCE_CNT, 8, consecutive stable cycles required to accept a press or a release. Must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cols  in  COLS  synchronized column lines, active-low (0 = key closed on the driven row).
- rows  out  ROWS  row drive, active-low one-cold (exactly one bit 0 at all times).
- key  out  KW=$clog2(ROWS*COLS)  encoded key, row*COLS+col, held until the next accepted press.
- key_valid  out  1  one-cycle pulse when a debounced press is accepted.
- key_held  out  1  high from the key_valid cycle until the debounced release completes.

Behaviour:
- Reset (synchronous, active-high):
  - state=SCAN, row index=0, rows=~1 (row 0 low).
  - dwell and debounce counters=0.
  - key=0, key_valid=0, key_held=0.
  - Reset asserted mid-debounce or mid-hold aborts with no key_valid and returns to these values.
- All outputs are registered.
- SCAN state:
  - Drive the current row for SCAN_DIV cycles; the dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle, sample cols.
  - If no column is low: advance the row index (ROWS-1 wraps to 0), clear dwell, update rows next cycle.
  - If any column is low: latch the row index and the lowest-index low column (fixed priority, col 0 highest), clear the debounce counter, go to PRESS_DB. The row stays driven.
- PRESS_DB state:
  - Each cycle, check the latched column.
  - Column low: increment the counter.
  - Column high: go to SCAN, advance to the next row, no output.
  - When the counter reaches DEBOUNCE_CNT-1 with the column still low:
    - the next cycle has key=latched code, key_valid=1, key_held=1;
    - go to HELD.
- HELD state:
  - Row remains driven; other rows are not scanned, so other keys are ignored.
  - Latched column goes high: clear the counter and go to REL_DB.
  - Changes on other columns are ignored.
- REL_DB state:
  - Latched column high for DEBOUNCE_CNT consecutive cycles:
    - key_held=0;
    - go to SCAN, advance the row index, dwell=0.
  - Column low again before that: return to HELD with no new key_valid (bounce suppression).
- key_valid is high for exactly one cycle per accepted press. It never re-fires while the same key is held.
- Latency:
  - press recognised at the sample point → key_valid exactly DEBOUNCE_CNT+1 cycles later;
  - release edge on cols → key_held falls DEBOUNCE_CNT+1 cycles later.
- Counters are sized $clog2 of their maximum plus 1 bit and saturate at their terminal value; they never wrap.

Decomposition:
- Shared package kscan_pkg:
  - state enum {SCAN, PRESS_DB, HELD, REL_DB};
  - default ROWS/COLS constants;
  - key-code width function.
- One natural sub-module: kscan_debounce.
  - Parameterised counter.
  - Inputs: start, level, target polarity.
  - Output: done, plus a fail pulse.
  - Reused for both PRESS_DB and REL_DB.
- Column priority encode stays inline.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8, ROWS=COLS=4; bench models the keypad by returning the column low when the pressed key's row is driven):
- Reset with no keys → rows cycles 1110, 1101, 1011, 0111, each for 4 cycles, then wraps. key_valid stays 0.
- Press row 2 col 1, stable → one key_valid pulse with key=9, key_held=1. The rows output freezes at 1011 while the key is held.
- Press row 1 col 3 asserted for 5 cycles then released, i.e. a bounce shorter than DEBOUNCE_CNT → no key_valid; scanning resumes at row 2.
- Hold key 0, then release with a 3-cycle high glitch followed by low again → no second key_valid. A final clean release drops key_held 9 cycles after the release edge.
- Row 0 with cols 0 and 2 low simultaneously → key=0 (lowest column wins). Exactly one pulse.
- Assert reset during PRESS_DB on the 4th debounce cycle → no key_valid. After reset, rows=1110, key=0, key_held=0.
